fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side drain engine for the dual-clock FIFO (read clock domain only).
//   Pops words through the FIFO read interface and presents them as a
//   valid/ready stream framed into packets of BURST beats. A 2-entry buffer
//   lets the FIFO be popped every cycle while out_valid/out_data/out_last
//   come straight from registers.
//
// Parameters
//   DSIZE : data word width (matches the FIFO)
//   BURST : beats per packet, 1..65535; out_last marks beat BURST
//   CW    : width of the saturating delivered-word counter
//
// Ports
//   rclk      in   read-domain clock
//   rrst      in   synchronous active-high reset
//   rempty    in   FIFO empty flag
//   rdata     in   FIFO data at the current read address (combinational)
//   rinc      out  FIFO pop strobe
//   flush     in   discard buffered words and packet position
//   out_valid out  stream data valid
//   out_ready in   downstream accept
//   out_data  out  stream data (buffer head)
//   out_last  out  final beat of the current packet
//   words_out out  count of completed transfers, saturating
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int CW    = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  output logic [CW-1:0]    words_out
);

  localparam int            BW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST - 1);
  localparam logic [CW-1:0] WORDS_MAX = {CW{1'b1}};

  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [CW-1:0]    words_q, words_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             rinc_s;
  logic             pop_s;

  // Buffer, packet-position and counter next-state logic
  always_comb begin
    // Pop only when there is room; flush and reset block it so the FIFO
    // never loses a word that would be discarded in the same cycle.
    rinc_s  = !rempty && (cnt_q != 2'd2) && !flush && !rrst;
    pop_s   = valid_q && out_ready && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    words_d = words_q;

    if (flush) begin
      cnt_d  = 2'd0;
      beat_d = '0;
    end else begin
      case ({rinc_s, pop_s})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_d = rdata;
          end else begin
            tail_d = rdata;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        // Only reachable with cnt==1: the old head leaves, the new word
        // replaces it and occupancy is unchanged.
        2'b11: begin
          head_d = rdata;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase

      if (pop_s) begin
        if (beat_q == BEAT_LAST) begin
          beat_d = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
        if (words_q != WORDS_MAX) begin
          words_d = words_q + CW'(1);
        end else begin
          words_d = words_q;
        end
      end else begin
        beat_d  = beat_q;
        words_d = words_q;
      end
    end

    // Output flags are precomputed so they leave the block from flops.
    valid_d = (cnt_d != 2'd0);
    last_d  = valid_d && (beat_d == BEAT_LAST);
  end

  // State registers with synchronous reset
  always_ff @(posedge rclk) begin
    if (rrst) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      beat_q  <= '0;
      words_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      words_q <= words_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign rinc      = rinc_s;
  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign out_last  = last_q;
  assign words_out = words_q;

endmodule
